// File: rtl/gemm_pkg.sv
// gemm_pkg: shared definitions for the output-feature-map write-back path.
//   DATA_WIDTH_DEF / PSUM_WIDTH_DEF : default element and partial-sum widths
//   wb_state_t                      : write-back controller states
//   sat_hi / sat_lo                 : signed saturation bounds for a given width
package gemm_pkg;

  localparam int DATA_WIDTH_DEF = 8;
  localparam int PSUM_WIDTH_DEF = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } wb_state_t;

  function automatic int sat_hi(input int width);
    return (1 << (width - 1)) - 1;
  endfunction

  function automatic int sat_lo(input int width);
    return -(1 << (width - 1));
  endfunction

endpackage

// File: rtl/quant_lane.sv
// quant_lane: one lane of requantization, purely combinational.
//   psum    : signed partial sum
//   shift   : arithmetic right shift with round-half-up (0 = pass through)
//   relu_en : clamp negative results to zero
//   q       : saturated signed output element
//   sat     : high when the value was clipped to the output range
module quant_lane
  import gemm_pkg::*;
#(
  parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
  parameter int PSUM_WIDTH  = PSUM_WIDTH_DEF,
  parameter int SHIFT_WIDTH = 5
) (
  input  logic signed [PSUM_WIDTH-1:0]  psum,
  input  logic        [SHIFT_WIDTH-1:0] shift,
  input  logic                          relu_en,
  output logic        [DATA_WIDTH-1:0]  q,
  output logic                          sat
);

  // One extra bit so that adding the rounding constant can never overflow.
  localparam int W = PSUM_WIDTH + 1;
  localparam logic signed [W-1:0] ONE = W'(1);
  localparam logic signed [W-1:0] HI  = W'(sat_hi(DATA_WIDTH));
  localparam logic signed [W-1:0] LO  = W'(sat_lo(DATA_WIDTH));

  logic signed [W-1:0] ext;
  logic signed [W-1:0] rnd;
  logic signed [W-1:0] r;

  always_comb begin
    ext = W'(psum);
    rnd = '0;
    r   = ext;
    if (shift != '0) begin
      rnd = ONE <<< (shift - SHIFT_WIDTH'(1));
      r   = (ext + rnd) >>> shift;
    end
    if (relu_en && r[W-1]) begin
      r = '0;
    end
    sat = 1'b0;
    if (r > HI) begin
      r   = HI;
      sat = 1'b1;
    end else if (r < LO) begin
      r   = LO;
      sat = 1'b1;
    end
    q = r[DATA_WIDTH-1:0];
  end

endmodule

// File: rtl/ofmap_writeback.sv
// ofmap_writeback: requantizing write-back engine, accumulator -> activation BRAM.
//   clk, rst                 : clock, async active-high reset
//   start_i + config inputs  : job start; base_addr/num_rows/shift/relu latched on start
//   psum_valid/ready/row     : PE_SIZE-lane partial-sum row handshake
//   mem_*                    : BRAM write port; a write retires when ce0&we0&mem_ready_i
//   busy_o, done_o           : job in progress, one-cycle end-of-job pulse
//   sat_cnt_o                : saturated lanes in the current job (sticky at 0xFFFF)
//
// state | meaning
// IDLE  | waiting for start_i
// RUN   | accepting rows until num_rows have been taken
// DRAIN | all rows accepted, waiting for the output word to retire
// DONE  | single cycle, done_o asserted
module ofmap_writeback
  import gemm_pkg::*;
#(
  parameter int PE_SIZE       = 14,
  parameter int DATA_WIDTH    = DATA_WIDTH_DEF,
  parameter int PSUM_WIDTH    = PSUM_WIDTH_DEF,
  parameter int ADDR_WIDTH    = 10,
  parameter int ROW_CNT_WIDTH = 10,
  parameter int SHIFT_WIDTH   = 5
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start_i,
  input  logic [ADDR_WIDTH-1:0]         base_addr_i,
  input  logic [ROW_CNT_WIDTH-1:0]      num_rows_i,
  input  logic [SHIFT_WIDTH-1:0]        shift_i,
  input  logic                          relu_en_i,
  input  logic                          psum_valid_i,
  output logic                          psum_ready_o,
  input  logic [PE_SIZE*PSUM_WIDTH-1:0] psum_row_i,
  input  logic                          mem_ready_i,
  output logic                          mem_ce0,
  output logic                          mem_we0,
  output logic [ADDR_WIDTH-1:0]         mem_addr0,
  output logic [PE_SIZE*DATA_WIDTH-1:0] mem_d0,
  output logic                          busy_o,
  output logic                          done_o,
  output logic [15:0]                   sat_cnt_o
);

  wb_state_t                     state, state_nxt;
  logic [ROW_CNT_WIDTH-1:0]      rows_left;
  logic [ADDR_WIDTH-1:0]         wr_addr;
  logic [SHIFT_WIDTH-1:0]        shift_q;
  logic                          relu_q;
  logic                          out_valid;
  logic [PE_SIZE*DATA_WIDTH-1:0] q_word;
  logic [PE_SIZE-1:0]            sat_flags;
  logic [16:0]                   sat_sum;
  logic                          accept;

  for (genvar k = 0; k < PE_SIZE; k++) begin : g_lane
    quant_lane #(
      .DATA_WIDTH (DATA_WIDTH),
      .PSUM_WIDTH (PSUM_WIDTH),
      .SHIFT_WIDTH(SHIFT_WIDTH)
    ) u_lane (
      .psum   (psum_row_i[k*PSUM_WIDTH +: PSUM_WIDTH]),
      .shift  (shift_q),
      .relu_en(relu_q),
      .q      (q_word[k*DATA_WIDTH +: DATA_WIDTH]),
      .sat    (sat_flags[k])
    );
  end

  // rows_left counts down from num_rows; the stage may take a new row while
  // the current word retires, which is what gives one row per cycle.
  assign psum_ready_o = (state == RUN) && (rows_left != '0) && (!out_valid || mem_ready_i);
  assign accept       = psum_valid_i && psum_ready_o;
  assign mem_ce0      = out_valid;
  assign mem_we0      = out_valid;

  always_comb begin
    sat_sum = {1'b0, sat_cnt_o};
    for (int k = 0; k < PE_SIZE; k++) begin
      sat_sum = sat_sum + 17'(sat_flags[k]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy_o    = 1'b0;
    done_o    = 1'b0;
    case (state)
      IDLE: begin
        if (start_i) state_nxt = (num_rows_i == '0) ? DONE : RUN;
      end
      RUN: begin
        busy_o = 1'b1;
        if (rows_left == '0) state_nxt = DRAIN;
      end
      DRAIN: begin
        busy_o = 1'b1;
        if (!out_valid) state_nxt = DONE;
      end
      DONE: begin
        done_o    = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rows_left <= '0;
      wr_addr   <= '0;
      shift_q   <= '0;
      relu_q    <= 1'b0;
      out_valid <= 1'b0;
      mem_addr0 <= '0;
      mem_d0    <= '0;
      sat_cnt_o <= '0;
    end else begin
      if (state == IDLE && start_i) begin
        rows_left <= num_rows_i;
        wr_addr   <= base_addr_i;
        shift_q   <= shift_i;
        relu_q    <= relu_en_i;
        sat_cnt_o <= '0;
      end
      if (accept) begin
        out_valid <= 1'b1;
        mem_d0    <= q_word;
        mem_addr0 <= wr_addr;
        wr_addr   <= wr_addr + ADDR_WIDTH'(1);
        rows_left <= rows_left - ROW_CNT_WIDTH'(1);
        sat_cnt_o <= sat_sum[16] ? 16'hFFFF : sat_sum[15:0];
      end else if (out_valid && mem_ready_i) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
